// File: rtl/hash_uart_loader.sv
// -----------------------------------------------------------------------------
// hash_uart_loader
//
// Streams a batch of 128-bit NTLM target hashes to the cracker over an 8N1
// UART line. Each hash is taken through a valid/ready handshake, buffered,
// and sent as 16 back-to-back bytes, MSB byte first, each byte LSB first.
// After NUM_HASHES hashes a one-cycle done pulse is raised and the loader
// returns to idle.
//
// Ports
//   clk         system clock, all state on the rising edge
//   n_rst       asynchronous active-low reset
//   start       one-cycle upload request, only honoured while idle
//   hash_valid  hash_data carries a valid hash
//   hash_data   128-bit hash, bit 127 is the MSB of the first byte sent
//   hash_ready  high only while waiting for the next hash
//   tx_line     registered serial output, idle high
//   busy        high whenever the loader is not idle
//   done        one-cycle pulse after the last stop bit of the batch
//   hash_count  hashes fully transmitted in the current upload
// -----------------------------------------------------------------------------
module hash_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned NUM_HASHES   = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         hash_valid,
  input  logic [127:0] hash_data,
  output logic         hash_ready,
  output logic         tx_line,
  output logic         busy,
  output logic         done,
  output logic [6:0]   hash_count
);

  // Bit-time counter runs 0..CLKS_PER_BIT-1; keep at least one bit wide.
  localparam int unsigned    TmrW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TmrW-1:0] TmrMax  = TmrW'(CLKS_PER_BIT - 1);
  localparam logic [6:0]      LastHash = 7'(NUM_HASHES);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StStop  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      byte_q, byte_d;
  logic [127:0]    buf_q, buf_d;
  logic [6:0]      count_q, count_d;
  logic            tx_q, tx_d;

  logic            tmr_done;
  logic [6:0]      count_inc;
  logic [3:0]      byte_rev;
  logic [7:0]      cur_byte;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    buf_d     = buf_q;
    count_d   = count_q;
    tmr_done  = (tmr_q == TmrMax);
    count_inc = count_q + 7'd1;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end

      StLoad: begin
        // hash_ready is high for the whole of this state, so valid alone
        // completes the handshake.
        if (hash_valid) begin
          buf_d   = hash_data;
          byte_d  = '0;
          bit_d   = '0;
          tmr_d   = '0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (tmr_done) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end

      StData: begin
        if (tmr_done) begin
          tmr_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end

      StStop: begin
        if (tmr_done) begin
          tmr_d = '0;
          if (byte_q == 4'd15) begin
            count_d = count_inc;
            state_d = (count_inc == LastHash) ? StDone : StLoad;
          end else begin
            byte_d  = byte_q + 4'd1;
            state_d = StStart;
          end
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Line level is derived from the upcoming state so the registered output
    // lines up exactly with the state it belongs to. Byte 0 is the top byte.
    byte_rev = 4'd15 - byte_d;
    cur_byte = buf_q[{byte_rev, 3'b000} +: 8];

    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      buf_q   <= '0;
      count_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      tx_q    <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hash_ready = (state_q == StLoad);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign tx_line    = tx_q;
  assign hash_count = count_q;

endmodule

// File: tb/tb_hash_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_hash_uart_loader
//
// Two loaders: dut (3 clocks/bit, 8 hashes) for streamed random uploads, gaps,
// ignored restarts and mid-frame reset; dut1 (4 clocks/bit, 1 hash) for a
// table of single-hash uploads with exact done timing. A UART receiver model
// decodes the selected line and compares every byte with the bytes split
// out of the hashes handed over at the handshake.
// -----------------------------------------------------------------------------
module tb_hash_uart_loader;

  localparam int C0 = 3;
  localparam int N0 = 8;
  localparam int C1 = 4;

  logic         clk;
  logic         n_rst;
  logic         start0, hash_valid0, hash_ready0, tx0, busy0, done0;
  logic [127:0] hash_data0;
  logic [6:0]   hash_count0;
  logic         start1, hash_valid1, hash_ready1, tx1, busy1, done1;
  logic [127:0] hash_data1;
  logic [6:0]   hash_count1;

  hash_uart_loader #(.CLKS_PER_BIT(C0), .NUM_HASHES(N0)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start0),
    .hash_valid (hash_valid0),
    .hash_data  (hash_data0),
    .hash_ready (hash_ready0),
    .tx_line    (tx0),
    .busy       (busy0),
    .done       (done0),
    .hash_count (hash_count0)
  );

  hash_uart_loader #(.CLKS_PER_BIT(C1), .NUM_HASHES(1)) dut1 (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start1),
    .hash_valid (hash_valid1),
    .hash_data  (hash_data1),
    .hash_ready (hash_ready1),
    .tx_line    (tx1),
    .busy       (busy1),
    .done       (done1),
    .hash_count (hash_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bytes in transmit order, and bytes actually decoded.
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  task automatic push_hash(input logic [127:0] h);
    for (int i = 0; i < 16; i++) exp_q.push_back(h[127-8*i -: 8]);
  endtask

  function automatic logic [127:0] rand_hash();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------------------------------------------------------------------
  // UART receiver model on the selected line
  // ---------------------------------------------------------------------------
  bit         mon_sel = 1'b0;
  logic       line;
  assign line = mon_sel ? tx1 : tx0;

  bit         rx_act;
  bit         shape_ok;
  int         rx_cnt, gap, byte_in_hash, k, cmon;
  logic [9:0] frame;
  logic [7:0] rb, eb;

  initial begin
    rx_act = 0; gap = 0; byte_in_hash = 0; rx_cnt = 0; frame = '0; shape_ok = 1;
    forever begin
      @(negedge clk);
      cmon = mon_sel ? C1 : C0;
      if (!n_rst) begin
        rx_act = 0; byte_in_hash = 0; gap = 0;
      end else begin
        if (!rx_act) begin
          if (line === 1'b0) begin
            // Bytes inside one hash must follow each other with no idle time.
            if (byte_in_hash != 0) check("byte_gap", gap, 0);
            rx_act = 1; rx_cnt = 0; shape_ok = 1;
          end else begin
            gap++;
          end
        end
        if (rx_act) begin
          k = rx_cnt / cmon;
          if (rx_cnt % cmon == 0) frame[k] = line;
          else if (line !== frame[k]) shape_ok = 0;
          rx_cnt++;
          if (rx_cnt == 10 * cmon) begin
            rx_act = 0; gap = 0;
            check("frame_stop", frame[9], 1'b1);
            check("bit_hold", shape_ok, 1'b1);
            rb = frame[8:1];
            rx_log.push_back(rb);
            check("rx_expected_avail", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
              eb = exp_q.pop_front();
              check("rx_byte", rb, eb);
            end
            byte_in_hash = (byte_in_hash + 1) % 16;
          end
        end
      end
    end
  end

  // hash_count must step by one; a clear is only legal when a start is expected.
  bit         cnt_clear_ok = 1'b0;
  logic [6:0] prev_cnt = '0;
  int         done_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_cnt = '0;
      end else if (hash_count0 !== prev_cnt) begin
        if (!(cnt_clear_ok && hash_count0 == 7'd0))
          check("hash_count_step", hash_count0, prev_cnt + 7'd1);
        prev_cnt = hash_count0;
      end
      if (done0 === 1'b1) begin
        done_cnt++;
        check("count_at_done", hash_count0, N0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Full upload on dut with random hashes
  // ---------------------------------------------------------------------------
  task automatic upload(input int gap_hash, input int gap_len, input int start_hash);
    int         w;
    bit         gap_ok;
    logic [7:0] first;
    mon_sel = 0;
    exp_q.delete(); rx_log.delete();
    done_cnt = 0; cnt_clear_ok = 1; first = '0;
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    for (int h = 0; h < N0; h++) begin
      w = 0;
      while (hash_ready0 !== 1'b1 && w < 200 * C0) begin @(negedge clk); w++; end
      check("ready_wait", hash_ready0, 1'b1);
      if (hash_ready0 !== 1'b1) return;
      if (h == gap_hash) begin
        gap_ok = 1;
        repeat (gap_len) begin
          @(negedge clk);
          if (tx0 !== 1'b1 || hash_ready0 !== 1'b1 || busy0 !== 1'b1) gap_ok = 0;
        end
        check("gap_idle_line", gap_ok, 1'b1);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      hash_data0 = rand_hash(); hash_valid0 = 1'b1;
      if (h == 0) first = hash_data0[127:120];
      push_hash(hash_data0);
      @(negedge clk);
      // Scramble the bus after capture; the frame must not follow it.
      hash_valid0 = 1'b0; hash_data0 = rand_hash(); cnt_clear_ok = 0;
      if (h == start_hash) begin start0 = 1'b1; @(negedge clk); start0 = 1'b0; end
    end
    w = 0;
    while (done_cnt == 0 && w < 200 * C0) begin @(negedge clk); w++; end
    repeat (5) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("final_hash_count", hash_count0, N0);
    check("busy_after_done", busy0, 1'b0);
    check("bytes_decoded", rx_log.size(), 16 * N0);
    check("bytes_left", exp_q.size(), 0);
    if (rx_log.size() != 0) check("first_byte", rx_log[0], first);
  endtask

  // ---------------------------------------------------------------------------
  // Single-hash vectors for dut1
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [127:0] hash;
    logic [7:0]   first_byte;
    logic [7:0]   last_byte;
  } vec_t;

  vec_t vecs[5];

  initial begin
    forever begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    int           w, t0;
    bit           idle_ok;
    logic [127:0] hb;

    vecs[0] = '{128'h8846F7EAEE8FB117AD06BDD830B7586C, 8'h88, 8'h6C};
    vecs[1] = '{128'h0123456789ABCDEF0011223344556677, 8'h01, 8'h77};
    vecs[2] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{128'h00000000000000000000000000000000, 8'h00, 8'h00};
    vecs[4] = '{128'h80A55A00000000000000000000C3FF01, 8'h80, 8'h01};

    n_rst = 1'b0;
    start0 = 0; hash_valid0 = 0; hash_data0 = '0;
    start1 = 0; hash_valid1 = 0; hash_data1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_ready", hash_ready0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_count", hash_count0, 7'd0);
    check("rst_tx1", tx1, 1'b1);
    check("rst_busy1", busy1, 1'b0);
    check("rst_ready1", hash_ready1, 1'b0);
    n_rst = 1'b1;

    // Idle for 50 cycles
    idle_ok = 1;
    repeat (50) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || hash_ready0 !== 1'b0 || done0 !== 1'b0) idle_ok = 0;
    end
    check("idle_50", idle_ok, 1'b1);
    check("idle_no_done", done_cnt, 0);

    // Table-driven single-hash uploads with valid held high
    for (int i = 0; i < 5; i++) begin
      mon_sel = 1;
      exp_q.delete(); rx_log.delete();
      hash_data1 = vecs[i].hash; hash_valid1 = 1'b1; start1 = 1'b1;
      push_hash(vecs[i].hash);
      @(negedge clk); start1 = 1'b0;
      w = 0;
      while (tx1 !== 1'b0 && w < 20) begin @(negedge clk); w++; end
      check("v_start_bit", tx1, 1'b0);
      t0 = cyc;
      w = 0;
      while (done1 !== 1'b1 && w < 160 * C1 + 20) begin @(negedge clk); w++; end
      check("v_done", done1, 1'b1);
      check("v_done_time", cyc - t0, 160 * C1);
      check("v_hash_count", hash_count1, 7'd1);
      @(negedge clk);
      check("v_done_width", done1, 1'b0);
      check("v_busy_after", busy1, 1'b0);
      hash_valid1 = 1'b0;
      check("v_nbytes", rx_log.size(), 16);
      if (rx_log.size() == 16) begin
        check("v_first_byte", rx_log[0], vecs[i].first_byte);
        check("v_last_byte", rx_log[15], vecs[i].last_byte);
      end
      repeat (3) @(negedge clk);
    end
    mon_sel = 0;

    // Streamed upload: 37-cycle valid gap before hash 5, restart during hash 3
    upload(4, 37, 2);
    // Plain random upload back-to-back with the previous one
    upload(-1, 0, -1);

    // Reset in DATA bit 4 of byte 7 of the second hash
    exp_q.delete(); rx_log.delete(); done_cnt = 0; cnt_clear_ok = 1;
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    hash_data0 = rand_hash(); hash_valid0 = 1'b1; push_hash(hash_data0);
    @(negedge clk); hash_valid0 = 1'b0; cnt_clear_ok = 0;
    w = 0;
    while (hash_ready0 !== 1'b1 && w < 300 * C0) begin @(negedge clk); w++; end
    check("rst_ready_b", hash_ready0, 1'b1);
    hb = rand_hash();
    hb[71:64] = 8'h00;  // byte 7 all zero, so the line is low at reset time
    hash_data0 = hb; hash_valid0 = 1'b1; push_hash(hb);
    @(negedge clk); hash_valid0 = 1'b0;
    check("rst_start_bit_b", tx0, 1'b0);
    check("rst_count_before", hash_count0, 7'd1);
    repeat (75 * C0 + 1) @(negedge clk);
    check("pre_reset_tx", tx0, 1'b0);
    check("pre_reset_busy", busy0, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_tx", tx0, 1'b1);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_count", hash_count0, 7'd0);
    check("mid_rst_ready", hash_ready0, 1'b0);
    check("mid_rst_done", done0, 1'b0);
    @(negedge clk);
    exp_q.delete(); rx_log.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_on_reset", done_cnt, 0);
    check("post_rst_tx", tx0, 1'b1);
    upload(-1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
